// File: rtl/alu_pkg.sv
// Shared opcode and FSM definitions for the multi-cycle ALU.
package alu_pkg;

  // Base opcodes, op_i[3:0] with op_i[4]=0
  localparam logic [3:0] AND             = 4'b0000;
  localparam logic [3:0] OR              = 4'b0001;
  localparam logic [3:0] SUM             = 4'b0010;
  localparam logic [3:0] EQUAL           = 4'b0011;
  localparam logic [3:0] SHIFT_LEFT      = 4'b0100;
  localparam logic [3:0] SHIFT_RIGHT     = 4'b0101;
  localparam logic [3:0] SHIFT_RIGHT_A   = 4'b0111;
  localparam logic [3:0] XOR             = 4'b1000;
  localparam logic [3:0] NOR             = 4'b1001;
  localparam logic [3:0] SUB             = 4'b1010;
  localparam logic [3:0] GREATER_EQUAL   = 4'b1100;
  localparam logic [3:0] GREATER_EQUAL_U = 4'b1101;
  localparam logic [3:0] SLT             = 4'b1110;
  localparam logic [3:0] SLT_U           = 4'b1111;

  // Mul/div funct codes, op_i[2:0] with op_i[4]=1, op_i[3]=0
  localparam logic [2:0] MUL    = 3'b000;
  localparam logic [2:0] MULH   = 3'b001;
  localparam logic [2:0] MULHSU = 3'b010;
  localparam logic [2:0] MULHU  = 3'b011;
  localparam logic [2:0] DIV    = 3'b100;
  localparam logic [2:0] DIVU   = 3'b101;
  localparam logic [2:0] REM    = 3'b110;
  localparam logic [2:0] REMU   = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    FIX  = 2'd2
  } md_state_t;

endpackage

// File: rtl/alu_muldiv_iter.sv
// Iterative multiply/divide unit: magnitude capture, WIDTH shift-add or
// restoring-divide steps, then sign correction and result selection.
// The registered result and done pulse appear two cycles after the last step.
module alu_muldiv_iter
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       funct,
  input  logic [WIDTH-1:0] rs1,
  input  logic [WIDTH-1:0] rs2,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] res
);

  localparam int SHW = $clog2(WIDTH);
  localparam logic [SHW-1:0] LAST = SHW'(WIDTH - 1);

  md_state_t state, state_nxt;

  logic [SHW-1:0]     cnt;
  logic [WIDTH-1:0]   hi, lo, dvs;
  logic [2:0]         fn;
  logic               neg_res, neg_rem, div0;
  logic               sa, sb;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [WIDTH:0]     mul_sum, div_tmp;
  logic               div_ge;
  logic [2*WIDTH-1:0] prod, sprod;
  logic [WIDTH-1:0]   quo, rmd, fix_res;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic: BUSY lasts WIDTH cycles
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = BUSY;
      BUSY:    if (cnt == LAST) state_nxt = FIX;
      FIX:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs: busy also covers the cycle in which done is presented
  always_comb begin
    busy = (state != IDLE) || done;
  end

  // Operand sign flags and magnitudes for the requested signedness
  always_comb begin
    sa = 1'b0;
    sb = 1'b0;
    case (funct)
      MULH, DIV, REM: begin
        sa = rs1[WIDTH-1];
        sb = rs2[WIDTH-1];
      end
      MULHSU:  sa = rs1[WIDTH-1];
      default: ;
    endcase
    mag_a = sa ? -rs1 : rs1;
    mag_b = sb ? -rs2 : rs2;
  end

  // One iteration step and the final sign fix-up / result selection.
  // Mul and div share {hi,lo}: product accumulator vs remainder/quotient.
  always_comb begin
    mul_sum = {1'b0, hi} + (lo[0] ? {1'b0, dvs} : '0);
    div_tmp = {hi, lo[WIDTH-1]};
    div_ge  = (div_tmp >= {1'b0, dvs});
    prod    = {hi, lo};
    sprod   = neg_res ? -prod : prod;
    quo     = div0 ? '1 : (neg_res ? -lo : lo);
    rmd     = neg_rem ? -hi : hi;
    case (fn)
      MUL:                 fix_res = sprod[WIDTH-1:0];
      MULH, MULHSU, MULHU: fix_res = sprod[2*WIDTH-1:WIDTH];
      DIV, DIVU:           fix_res = quo;
      default:             fix_res = rmd;
    endcase
  end

  // Datapath registers: capture, iterate, fix
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt     <= '0;
      hi      <= '0;
      lo      <= '0;
      dvs     <= '0;
      fn      <= '0;
      neg_res <= 1'b0;
      neg_rem <= 1'b0;
      div0    <= 1'b0;
      res     <= '0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            cnt     <= '0;
            hi      <= '0;
            lo      <= mag_a;
            dvs     <= mag_b;
            fn      <= funct;
            neg_res <= sa ^ sb;
            neg_rem <= sa;
            div0    <= (rs2 == '0);
          end
        end
        BUSY: begin
          cnt <= cnt + 1'b1;
          if (!fn[2]) begin
            hi <= mul_sum[WIDTH:1];
            lo <= {mul_sum[0], lo[WIDTH-1:1]};
          end else begin
            hi <= div_ge ? WIDTH'(div_tmp - {1'b0, dvs}) : div_tmp[WIDTH-1:0];
            lo <= {lo[WIDTH-2:0], div_ge};
          end
        end
        FIX: begin
          res  <= fix_res;
          done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle RISC-V ALU: registered single-cycle base ops plus an optional
// iterative mul/div unit. Define ALU_MULDIV_EN to build the mul/div path;
// without it every op_i[4]=1 code returns 0 with base timing.
module alu_mc
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       op_i,
  input  logic [WIDTH-1:0] rs1_i,
  input  logic [WIDTH-1:0] rs2_i,
  input  logic             valid_i,
  output logic             ready_o,
  output logic             valid_o,
  output logic [WIDTH-1:0] rd_o,
  output logic             zr_o
);

  localparam int SHW = $clog2(WIDTH);

  logic             accept;
  logic             md_start, md_busy, md_done;
  logic [WIDTH-1:0] md_res;
  logic [WIDTH-1:0] base_res;
  logic [SHW-1:0]   shamt;

  assign accept = valid_i && ready_o;
  assign shamt  = rs2_i[SHW-1:0];

`ifdef ALU_MULDIV_EN
  assign md_start = accept && op_i[4] && !op_i[3];

  alu_muldiv_iter #(.WIDTH(WIDTH)) u_iter (
    .clk   (clk),
    .rst   (rst),
    .start (md_start),
    .funct (op_i[2:0]),
    .rs1   (rs1_i),
    .rs2   (rs2_i),
    .busy  (md_busy),
    .done  (md_done),
    .res   (md_res)
  );
`else
  assign md_start = 1'b0;
  assign md_busy  = 1'b0;
  assign md_done  = 1'b0;
  assign md_res   = '0;
`endif

  assign ready_o = !md_busy;

  // Base combinational datapath; any op_i[4]=1 code not taken by the
  // iterative unit falls through to zero here
  always_comb begin
    base_res = '0;
    if (!op_i[4]) begin
      case (op_i[3:0])
        AND:             base_res = rs1_i & rs2_i;
        OR:              base_res = rs1_i | rs2_i;
        SUM:             base_res = rs1_i + rs2_i;
        SUB:             base_res = rs1_i - rs2_i;
        XOR:             base_res = rs1_i ^ rs2_i;
        NOR:             base_res = ~(rs1_i | rs2_i);
        EQUAL:           base_res = WIDTH'(rs1_i == rs2_i);
        GREATER_EQUAL:   base_res = WIDTH'($signed(rs1_i) >= $signed(rs2_i));
        GREATER_EQUAL_U: base_res = WIDTH'(rs1_i >= rs2_i);
        SLT:             base_res = WIDTH'($signed(rs1_i) < $signed(rs2_i));
        SLT_U:           base_res = WIDTH'(rs1_i < rs2_i);
        SHIFT_LEFT:      base_res = rs1_i << shamt;
        SHIFT_RIGHT:     base_res = rs1_i >> shamt;
        SHIFT_RIGHT_A:   base_res = $unsigned($signed(rs1_i) >>> shamt);
        default:         base_res = '0;
      endcase
    end
  end

  // Result register: mul/div completion or base op at the accepting edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_o    <= '0;
      zr_o    <= 1'b1;
      valid_o <= 1'b0;
    end else if (md_done) begin
      rd_o    <= md_res;
      zr_o    <= (md_res == '0);
      valid_o <= 1'b1;
    end else if (accept && !md_start) begin
      rd_o    <= base_res;
      zr_o    <= (base_res == '0);
      valid_o <= 1'b1;
    end else begin
      valid_o <= 1'b0;
    end
  end

endmodule
